// File: rtl/lwb_pkg.sv
// Shared constants and helpers for the line window buffer and neighbouring pipeline stages.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default pixel width and geometry, clog2_safe, default counter widths.
package lwb_pkg;

  // Pixel width shared by every stage of the haze-removal pipeline (RGB888).
  localparam int LWB_DATA_W = 24;
  localparam int LWB_IMG_W  = 512;
  localparam int LWB_KSIZE  = 3;

  // ceil(log2(n)) but never less than 1, so one-entry ranges still get a real bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Counter widths for the default geometry.
  localparam int COL_W = clog2_safe(LWB_IMG_W);
  localparam int LF_W  = clog2_safe(LWB_KSIZE);

endpackage

// File: rtl/lwb_line_ram.sv
// One stored image line: 1R1W RAM, synchronous write, asynchronous read (distributed-RAM style).
// Latency: read is combinational, write lands at the clock edge. Backpressure: none, caller gates we.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port. Contents are never reset.
module lwb_line_ram
  import lwb_pkg::*;
#(
  parameter int DATA_W = LWB_DATA_W,
  parameter int DEPTH  = LWB_IMG_W,
  parameter int ADDR_W = clog2_safe(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read sees the pre-write contents in the cycle of a same-address write.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/line_window_buffer.sv
// Raster pixel stream in, one KSIZE-tap vertical column out per accepted pixel (tap k = k lines above).
// Latency: 1 cycle from accepted beat to out_valid. Backpressure: single output register, no skid;
// in_ready = !out_valid | out_ready, combinational. Ports: in_* stream (with in_sof), out_* column stream.
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int DATA_W = LWB_DATA_W,
  parameter int IMG_W  = LWB_IMG_W,
  parameter int KSIZE  = LWB_KSIZE,
  parameter int BORDER = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            in_pixel,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic                         in_ready,
  output logic [KSIZE*DATA_W-1:0]      out_column,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [clog2_safe(IMG_W)-1:0] out_col,
  output logic                         out_row_ok
);

  // The default geometry reuses the shared widths; other geometries derive their own.
  localparam int COL_BITS = (IMG_W == LWB_IMG_W) ? COL_W : clog2_safe(IMG_W);
  localparam int LF_BITS  = (KSIZE == LWB_KSIZE) ? LF_W  : clog2_safe(KSIZE);

  logic                      acc;
  logic                      load;
  logic                      last_col;
  logic                      lf_full;
  logic [COL_BITS-1:0]       col_q, col_d, col_eff;
  logic [LF_BITS-1:0]        lf_q, lf_d, lf_eff;
  logic [DATA_W-1:0]         rd_dat [KSIZE-1];
  logic [DATA_W-1:0]         tap    [KSIZE];
  logic [KSIZE*DATA_W-1:0]   column_q, column_d;
  logic [COL_BITS-1:0]       out_col_q, out_col_d;
  logic                      out_vld_q, out_vld_d;
  logic                      row_ok_q, row_ok_d;

  assign in_ready = !out_vld_q | out_ready;
  assign acc      = in_valid & in_ready;

  // A start-of-frame beat is handled as if the counters had just been reset.
  assign col_eff  = in_sof ? '0 : col_q;
  assign lf_eff   = in_sof ? '0 : lf_q;
  assign last_col = (col_eff == COL_BITS'(IMG_W - 1));
  assign lf_full  = (lf_eff == LF_BITS'(KSIZE - 1));
  assign load     = acc & ((BORDER != 0) | lf_full);

  // Line memories form a vertical shift chain: each one takes the old word of
  // the line below it at the same column, line 0 takes the incoming pixel.
  for (genvar j = 0; j < KSIZE - 1; j++) begin : g_line
    logic [DATA_W-1:0] wr_dat;
    if (j == 0) begin : g_first
      assign wr_dat = in_pixel;
    end else begin : g_chain
      assign wr_dat = rd_dat[j-1];
    end
    lwb_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (acc),
      .waddr (col_eff),
      .wdata (wr_dat),
      .raddr (col_eff),
      .rdata (rd_dat[j])
    );
  end

  always_comb begin
    tap[0] = in_pixel;
    for (int k = 1; k < KSIZE; k++) tap[k] = rd_dat[k-1];
  end

  // Column / frame-row counters.
  always_comb begin
    col_d = col_q;
    lf_d  = lf_q;
    if (acc) begin
      col_d = last_col ? '0 : col_eff + 1'b1;
      lf_d  = (last_col && !lf_full) ? lf_eff + 1'b1 : lf_eff;
    end
  end

  // Output register: load wins over consumption, so a simultaneous
  // pop and push keeps out_valid high with the new word.
  always_comb begin
    column_d  = column_q;
    out_col_d = out_col_q;
    out_vld_d = out_vld_q;
    row_ok_d  = row_ok_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_col_d = col_eff;
      row_ok_d  = lf_full;
      for (int k = 0; k < KSIZE; k++) begin
        // Near the top edge, taps above the oldest stored line repeat that line.
        if ((BORDER != 0) && (k > int'(lf_eff))) column_d[k*DATA_W +: DATA_W] = tap[lf_eff];
        else                                      column_d[k*DATA_W +: DATA_W] = tap[k];
      end
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      lf_q      <= '0;
      column_q  <= '0;
      out_col_q <= '0;
      out_vld_q <= 1'b0;
      row_ok_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      lf_q      <= lf_d;
      column_q  <= column_d;
      out_col_q <= out_col_d;
      out_vld_q <= out_vld_d;
      row_ok_q  <= row_ok_d;
    end
  end

  assign out_column = column_q;
  assign out_col    = out_col_q;
  assign out_valid  = out_vld_q;
  assign out_row_ok = row_ok_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: four geometries share one input stream, each checked against a scoreboard.
// Instances: A (W4 K3 B0), B (W4 K3 B1), C (W5 K7 B0), D (W512 K2 B1).
// Stimulus is a linear sequence of directed steps followed by a random-handshake multi-frame run.
module tb_line_window_buffer;

  typedef struct {
    logic [167:0] w;
    logic [8:0]   c;
    logic         ok;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [23:0] in_pixel;
  logic        in_valid;
  logic        in_sof;
  logic        out_ready;

  logic [71:0]  a_cw, b_cw;
  logic [167:0] c_cw;
  logic [47:0]  d_cw;
  logic [1:0]   a_oc, b_oc;
  logic [2:0]   c_oc;
  logic [8:0]   d_oc;
  logic         a_rdy, b_rdy, c_rdy, d_rdy;
  logic         a_vld, b_vld, c_vld, d_vld;
  logic         a_ok, b_ok, c_ok, d_ok;

  logic         iv_rdy [4];
  logic         o_vld  [4];
  logic         o_ok   [4];
  logic [8:0]   o_col  [4];
  logic [167:0] o_word [4];

  int cmp_cnt = 0;
  int err_cnt = 0;

  exp_t         sb [4][$];
  exp_t         cap_a[$], cap_b[$], ref_a[$], ref_b[$];
  logic [23:0]  hist [4][8][512];
  int           mrow [4];
  int           mcol [4];
  logic         pend [4];
  logic         hold [4];
  logic [167:0] hold_w [4];

  line_window_buffer #(.DATA_W(24), .IMG_W(4), .KSIZE(3), .BORDER(0)) u_a (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(a_rdy), .out_column(a_cw), .out_valid(a_vld), .out_ready(out_ready),
    .out_col(a_oc), .out_row_ok(a_ok));
  line_window_buffer #(.DATA_W(24), .IMG_W(4), .KSIZE(3), .BORDER(1)) u_b (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(b_rdy), .out_column(b_cw), .out_valid(b_vld), .out_ready(out_ready),
    .out_col(b_oc), .out_row_ok(b_ok));
  line_window_buffer #(.DATA_W(24), .IMG_W(5), .KSIZE(7), .BORDER(0)) u_c (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(c_rdy), .out_column(c_cw), .out_valid(c_vld), .out_ready(out_ready),
    .out_col(c_oc), .out_row_ok(c_ok));
  line_window_buffer #(.DATA_W(24), .IMG_W(512), .KSIZE(2), .BORDER(1)) u_d (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(d_rdy), .out_column(d_cw), .out_valid(d_vld), .out_ready(out_ready),
    .out_col(d_oc), .out_row_ok(d_ok));

  assign iv_rdy[0] = a_rdy;  assign iv_rdy[1] = b_rdy;  assign iv_rdy[2] = c_rdy;  assign iv_rdy[3] = d_rdy;
  assign o_vld[0]  = a_vld;  assign o_vld[1]  = b_vld;  assign o_vld[2]  = c_vld;  assign o_vld[3]  = d_vld;
  assign o_ok[0]   = a_ok;   assign o_ok[1]   = b_ok;   assign o_ok[2]   = c_ok;   assign o_ok[3]   = d_ok;
  assign o_col[0]  = 9'(a_oc);   assign o_col[1]  = 9'(b_oc);
  assign o_col[2]  = 9'(c_oc);   assign o_col[3]  = d_oc;
  assign o_word[0] = 168'(a_cw); assign o_word[1] = 168'(b_cw);
  assign o_word[2] = c_cw;       assign o_word[3] = 168'(d_cw);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pw(input int i);
    case (i)
      0, 1:    return 4;
      2:       return 5;
      default: return 512;
    endcase
  endfunction
  function automatic int pk(input int i);
    case (i)
      0, 1:    return 3;
      2:       return 7;
      default: return 2;
    endcase
  endfunction
  function automatic int pb(input int i);
    return (i == 1 || i == 3) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and reference model, evaluated mid-cycle for every instance.
  // The model keeps the current frame as rows of pixels and looks taps up by row number.
  always @(negedge clk) begin
    int   r, c, sr, kk;
    exp_t e;
    logic [23:0] tv;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        sb[i].delete();
        mrow[i] = 0; mcol[i] = 0; pend[i] = 1'b0; hold[i] = 1'b0;
      end else begin
        chk("in_ready", 192'(iv_rdy[i]), 192'(!o_vld[i] | out_ready));
        if (pend[i]) begin
          chk("latency", 192'(o_vld[i]), 192'(1));
          pend[i] = 1'b0;
        end
        if (hold[i]) begin
          chk("hold_valid", 192'(o_vld[i]), 192'(1));
          chk("hold_data", 192'(o_word[i]), 192'(hold_w[i]));
        end
        hold[i]   = o_vld[i] & !out_ready;
        hold_w[i] = o_word[i];
        if (o_vld[i] && out_ready) begin
          if (sb[i].size() == 0) begin
            chk("unexpected_valid", 192'(o_vld[i]), 192'(0));
          end else begin
            e = sb[i].pop_front();
            chk("column", 192'(o_word[i]), 192'(e.w));
            chk("out_col", 192'(o_col[i]), 192'(e.c));
            chk("row_ok", 192'(o_ok[i]), 192'(e.ok));
            if (i == 0) cap_a.push_back(e);
            if (i == 1) cap_b.push_back(e);
          end
        end
        if (in_valid && iv_rdy[i]) begin
          if (in_sof) begin mrow[i] = 0; mcol[i] = 0; end
          r  = mrow[i];
          c  = mcol[i];
          kk = pk(i);
          if (pb(i) == 1 || r >= kk - 1) begin
            e.w  = '0;
            e.c  = 9'(c);
            e.ok = (r >= kk - 1);
            for (int k = 0; k < kk; k++) begin
              sr = r - k;
              if (sr < 0) sr = 0;
              tv = (sr == r) ? in_pixel : hist[i][sr % 8][c];
              e.w[k*24 +: 24] = tv;
            end
            sb[i].push_back(e);
            pend[i] = 1'b1;
          end
          hist[i][r % 8][c] = in_pixel;
          c++;
          if (c == pw(i)) begin c = 0; r++; end
          mrow[i] = r;
          mcol[i] = c;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, 192'(o_vld[i]), 192'(0));
      chk({tag, "_column"}, 192'(o_word[i]), 192'(0));
      chk({tag, "_col"}, 192'(o_col[i]), 192'(0));
      chk({tag, "_row_ok"}, 192'(o_ok[i]), 192'(0));
    end
  endtask

  // Streams pixels 1..n; advances when instance A accepts. Optional sof and out_ready stall window.
  task automatic run_stream(input int n, input int sof_at, input int stall_start, input int stall_len);
    int idx;
    idx = 0;
    for (int cyc = 0; cyc < n * 4 + 50 && idx < n; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      in_valid  = 1'b1;
      in_pixel  = 24'(idx + 1);
      in_sof    = (idx + 1 == sof_at);
      @(negedge clk);
      if (stall_len > 0 && cyc == stall_start + 2) begin
        chk("bp_in_ready", 192'(a_rdy), 192'(0));
        chk("bp_out_valid", 192'(a_vld), 192'(1));
      end
      if (a_rdy) idx++;
    end
    chk("stream_beats", 192'(idx), 192'(n));
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic cmp_list(input string tag, input exp_t got[$], input exp_t want[$]);
    chk({tag, "_count"}, 192'(got.size()), 192'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      chk({tag, "_word"}, 192'(got[i].w), 192'(want[i].w));
      chk({tag, "_col"}, 192'(got[i].c), 192'(want[i].c));
    end
  endtask

  initial begin
    int   acc_n;
    logic last_acc;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("reset");
    chk("reset_in_ready", 192'(a_rdy), 192'(1));

    // Priming: continuous stream 1..12.
    cap_a.delete(); cap_b.delete();
    run_stream(12, -1, -100, 0);
    drain();
    chk("prime_a_count", 192'(cap_a.size()), 192'(4));
    chk("prime_a_first", 192'(cap_a[0].w), 192'({24'd1, 24'd5, 24'd9}));
    chk("prime_a_first_col", 192'(cap_a[0].c), 192'(0));
    chk("prime_a_last", 192'(cap_a[3].w), 192'({24'd4, 24'd8, 24'd12}));
    chk("prime_a_last_col", 192'(cap_a[3].c), 192'(3));
    chk("border_count", 192'(cap_b.size()), 192'(12));
    chk("border_px1", 192'(cap_b[0].w), 192'({24'd1, 24'd1, 24'd1}));
    chk("border_px1_ok", 192'(cap_b[0].ok), 192'(0));
    chk("border_px6", 192'(cap_b[5].w), 192'({24'd2, 24'd2, 24'd6}));
    chk("border_px9", 192'(cap_b[8].w), 192'({24'd1, 24'd5, 24'd9}));
    chk("border_px9_ok", 192'(cap_b[8].ok), 192'(1));
    ref_a = cap_a;
    ref_b = cap_b;

    // Backpressure: 5 stalled cycles mid-line must not change the output sequence.
    do_reset();
    cap_a.delete(); cap_b.delete();
    run_stream(12, -1, 9, 5);
    drain();
    cmp_list("bp_a", cap_a, ref_a);
    cmp_list("bp_b", cap_b, ref_b);

    // Frame restart on pixel 7: first window is {7,11,15} at column 0.
    do_reset();
    cap_a.delete(); cap_b.delete();
    run_stream(20, 7, -100, 0);
    drain();
    chk("sof_a_count", 192'(cap_a.size()), 192'(6));
    chk("sof_a_first", 192'(cap_a[0].w), 192'({24'd7, 24'd11, 24'd15}));
    chk("sof_a_first_col", 192'(cap_a[0].c), 192'(0));

    // Reset mid-line with an output held, then replay the priming stream.
    do_reset();
    run_stream(6, -1, -100, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk_zero("midreset");
    out_ready = 1'b1;
    cap_a.delete(); cap_b.delete();
    run_stream(12, -1, -100, 0);
    drain();
    cmp_list("replay_a", cap_a, ref_a);
    cmp_list("replay_b", cap_b, ref_b);

    // Random handshakes over 3 frames of 2560 beats (5x512 lines / 512x5 lines).
    acc_n = 0;
    last_acc = 1'b0;
    for (int cyc = 0; cyc < 40000 && acc_n < 7680; cyc++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (last_acc || !in_valid) begin
        in_pixel = 24'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      in_sof = (acc_n % 2560 == 0);
      @(negedge clk);
      last_acc = in_valid && a_rdy;
      if (last_acc) acc_n++;
    end
    chk("sweep_beats", 192'(acc_n), 192'(7680));
    drain();
    for (int i = 0; i < 4; i++) chk("sb_empty", 192'(sb[i].size()), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
